// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM arbiter.
//   grant_t     - which requester owns the RAM in the current cycle
//   req_state_t - per-requester issue state (IDLE / PENDING)
//   ROM_TAG and its bit positions - address region where writes are dropped
//   LG_CPU / LG_VDP - encoding of the 1-bit lastGrant register
package mem_arb_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_VDP  = 2'd2
   } grant_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } req_state_t;

   localparam logic [1:0] ROM_TAG     = 2'b00;
   localparam int         ROM_TAG_MSB = 15;
   localparam int         ROM_TAG_LSB = 14;

   localparam logic LG_CPU = 1'b0;
   localparam logic LG_VDP = 1'b1;

   function automatic logic is_rom(input logic [1:0] tag);
      return (tag == ROM_TAG);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-input round-robin arbiter with an urgent override.
// Purely combinational; the lastGrant register lives in the parent.
//   i_req[0]     - CPU eligible
//   i_req[1]     - VDP eligible
//   i_urgent     - VDP urgent; an eligible urgent VDP always wins
//   i_last_grant - requester granted most recently (LG_CPU / LG_VDP)
//   o_grant      - one-hot grant, bit order as i_req; zero when nothing eligible
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_urgent,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_req[1] && i_urgent) begin
         o_grant = 2'b10;
      end else if (i_req == 2'b11) begin
         // Tie: whoever was not served last goes now.
         o_grant = (i_last_grant == LG_VDP) ? 2'b01 : 2'b10;
      end else begin
         o_grant = i_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous RAM (1-cycle read latency)
// between the CPU bus and the VDP fetch port. One access is issued per cycle;
// the RAM controls are driven combinationally from the winner in the issue
// cycle and the winner's ack pulses in the following cycle.
//
// Handshake: a requester raises its req and holds it (with stable command)
// until its ack pulse. The ack arrives exactly one cycle after the issue
// cycle, and the read data is valid only while ack is high. Dropping req
// early does not cancel an issued access.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   cpuReq/cpuWrite/cpuAddr/cpuWData -> cpuAck/cpuRData : CPU read/write port
//   vdpReq/vdpUrgent/vdpAddr    -> vdpAck/vdpRData      : VDP read-only port
//   ramAddr/ramWe/ramWData      -> ramRData             : RAM side
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpuReq,
   input  logic              cpuWrite,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic              cpuAck,
   output logic [DATA_W-1:0] cpuRData,
   input  logic              vdpReq,
   input  logic              vdpUrgent,
   input  logic [ADDR_W-1:0] vdpAddr,
   output logic              vdpAck,
   output logic [DATA_W-1:0] vdpRData,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [DATA_W-1:0] ramWData,
   input  logic [DATA_W-1:0] ramRData
);

   req_state_t        r_cpu_st, w_cpu_st_nxt;
   req_state_t        r_vdp_st, w_vdp_st_nxt;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_addr_sh;
   logic [DATA_W-1:0] r_wdata_sh;

   logic [1:0]        w_elig;
   logic [1:0]        w_onehot;
   grant_t            w_grant;
   logic [ADDR_W-1:0] w_addr;
   logic              w_we;
   logic [DATA_W-1:0] w_wdata;

   // A PENDING requester is never eligible; nothing issues during reset.
   assign w_elig[0] = cpuReq && (r_cpu_st == ST_IDLE) && !reset;
   assign w_elig[1] = vdpReq && (r_vdp_st == ST_IDLE) && !reset;

   rr_arbiter2 u_rr (
      .i_req        (w_elig),
      .i_urgent     (vdpUrgent),
      .i_last_grant (r_last_grant),
      .o_grant      (w_onehot)
   );

   always_comb begin
      w_grant = GNT_NONE;
      if (w_onehot[0]) begin
         w_grant = GNT_CPU;
      end else if (w_onehot[1]) begin
         w_grant = GNT_VDP;
      end
   end

   // Per-requester FSM: IDLE -> PENDING on grant, PENDING -> IDLE next cycle.
   always_comb begin
      w_cpu_st_nxt = r_cpu_st;
      w_vdp_st_nxt = r_vdp_st;
      case (r_cpu_st)
         ST_IDLE:    if (w_grant == GNT_CPU) w_cpu_st_nxt = ST_PENDING;
         ST_PENDING: w_cpu_st_nxt = ST_IDLE;
         default:    w_cpu_st_nxt = ST_IDLE;
      endcase
      case (r_vdp_st)
         ST_IDLE:    if (w_grant == GNT_VDP) w_vdp_st_nxt = ST_PENDING;
         ST_PENDING: w_vdp_st_nxt = ST_IDLE;
         default:    w_vdp_st_nxt = ST_IDLE;
      endcase
   end

   // RAM controls. Idle cycles and VDP issues (which carry no data) hold the
   // previous address/data from the shadows so the RAM bus does not toggle.
   always_comb begin
      w_addr  = r_addr_sh;
      w_wdata = r_wdata_sh;
      w_we    = 1'b0;
      case (w_grant)
         GNT_CPU: begin
            w_addr  = cpuAddr;
            w_wdata = cpuWData;
            // ROM-region writes are issued and acked but never reach the RAM.
            w_we    = cpuWrite && !is_rom(cpuAddr[ROM_TAG_MSB:ROM_TAG_LSB]);
         end
         GNT_VDP: begin
            w_addr  = vdpAddr;
         end
         default: begin
         end
      endcase
      if (reset) begin
         w_addr  = '0;
         w_wdata = '0;
         w_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpu_st     <= ST_IDLE;
         r_vdp_st     <= ST_IDLE;
         r_last_grant <= LG_VDP;
         r_addr_sh    <= '0;
         r_wdata_sh   <= '0;
      end else begin
         r_cpu_st   <= w_cpu_st_nxt;
         r_vdp_st   <= w_vdp_st_nxt;
         r_addr_sh  <= w_addr;
         r_wdata_sh <= w_wdata;
         if (w_grant == GNT_CPU) begin
            r_last_grant <= LG_CPU;
         end else if (w_grant == GNT_VDP) begin
            r_last_grant <= LG_VDP;
         end
      end
   end

   assign ramAddr  = w_addr;
   assign ramWe    = w_we;
   assign ramWData = w_wdata;

   // Ack comes from the registered PENDING state; a reset in the ack cycle
   // suppresses it so an aborted access never completes.
   assign cpuAck   = (r_cpu_st == ST_PENDING) && !reset;
   assign vdpAck   = (r_vdp_st == ST_PENDING) && !reset;
   assign cpuRData = ramRData;
   assign vdpRData = ramRData;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              cpu_req, cpu_write, cpu_ack;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              vdp_req, vdp_urgent, vdp_ack;
   logic [ADDR_W-1:0] vdp_addr;
   logic [DATA_W-1:0] vdp_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpuReq    (cpu_req),
      .cpuWrite  (cpu_write),
      .cpuAddr   (cpu_addr),
      .cpuWData  (cpu_wdata),
      .cpuAck    (cpu_ack),
      .cpuRData  (cpu_rdata),
      .vdpReq    (vdp_req),
      .vdpUrgent (vdp_urgent),
      .vdpAddr   (vdp_addr),
      .vdpAck    (vdp_ack),
      .vdpRData  (vdp_rdata),
      .ramAddr   (ram_addr),
      .ramWe     (ram_we),
      .ramWData  (ram_wdata),
      .ramRData  (ram_rdata)
   );

   // ---------------- RAM model (synchronous, 1-cycle read) ----------------
   logic [DATA_W-1:0] ram_mem  [0:65535];
   logic [DATA_W-1:0] gold_mem [0:65535];
   logic              ram_load;

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 65536; i++) ram_mem[i] <= gold_mem[i];
      end else begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   // Each cycle: who is allowed to go, who wins, what the RAM must see,
   // and what each requester is owed one cycle later.
   logic [DATA_W-1:0] cpu_exp_q[$];
   logic [DATA_W-1:0] vdp_exp_q[$];
   int                issue_log[$];   // 0 none, 1 CPU, 2 VDP per non-reset cycle
   logic              exp_cpu_ack, exp_vdp_ack, exp_cpu_wr, last_vdp;
   logic [ADDR_W-1:0] sh_addr;
   logic [DATA_W-1:0] sh_wdata;
   logic              cpu_active, vdp_active;

   task automatic model_cycle();
      logic              el_c, el_v, e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] d;
      int                win;
      if (reset) begin
         check("rst_cpu_ack", 32'(cpu_ack), 32'(1'b0));
         check("rst_vdp_ack", 32'(vdp_ack), 32'(1'b0));
         check("rst_ram_we", 32'(ram_we), 32'(1'b0));
         check("rst_ram_addr", 32'(ram_addr), 32'(16'h0));
         check("rst_ram_wdata", 32'(ram_wdata), 32'(8'h0));
         exp_cpu_ack = 1'b0;
         exp_vdp_ack = 1'b0;
         exp_cpu_wr  = 1'b0;
         last_vdp    = 1'b1;
         sh_addr     = '0;
         sh_wdata    = '0;
         cpu_exp_q.delete();
         vdp_exp_q.delete();
         cpu_active  = 1'b0;
         vdp_active  = 1'b0;
         return;
      end
      // completions owed from last cycle
      check("cpu_ack", 32'(cpu_ack), 32'(exp_cpu_ack));
      check("vdp_ack", 32'(vdp_ack), 32'(exp_vdp_ack));
      if (exp_cpu_ack && cpu_exp_q.size() > 0) begin
         d = cpu_exp_q.pop_front();
         if (!exp_cpu_wr) check("cpu_rdata", 32'(cpu_rdata), 32'(d));
         cpu_active = 1'b0;
      end
      if (exp_vdp_ack && vdp_exp_q.size() > 0) begin
         d = vdp_exp_q.pop_front();
         check("vdp_rdata", 32'(vdp_rdata), 32'(d));
         vdp_active = 1'b0;
      end
      // a requester that completes this cycle was issued last cycle -> busy
      el_c = cpu_req && !exp_cpu_ack;
      el_v = vdp_req && !exp_vdp_ack;
      if (el_v && vdp_urgent)  win = 2;
      else if (el_c && el_v)   win = last_vdp ? 1 : 2;
      else if (el_c)           win = 1;
      else if (el_v)           win = 2;
      else                     win = 0;
      issue_log.push_back(win);

      e_we   = 1'b0;
      e_addr = sh_addr;
      if (win == 1) begin
         e_addr = cpu_addr;
         e_we   = cpu_write && (cpu_addr[15:14] != 2'b00);
      end else if (win == 2) begin
         e_addr = vdp_addr;
      end
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_we", 32'(ram_we), 32'(e_we));
      if (win == 1) check("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
      if (win == 0) check("ram_wdata_hold", 32'(ram_wdata), 32'(sh_wdata));

      exp_cpu_ack = (win == 1);
      exp_vdp_ack = (win == 2);
      if (win == 1) begin
         exp_cpu_wr = cpu_write;
         cpu_exp_q.push_back(gold_mem[cpu_addr]);
         last_vdp = 1'b0;
         sh_wdata = cpu_wdata;
      end else if (win == 2) begin
         vdp_exp_q.push_back(gold_mem[vdp_addr]);
         last_vdp = 1'b1;
      end
      sh_addr = e_addr;
      if (e_we) gold_mem[e_addr] = cpu_wdata;
   endtask

   // ---------------- driver tasks ----------------
   task automatic sample();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample();
      advance();
      reset = 1'b0;
   endtask

   task automatic drive_random();
      logic [31:0] r;
      if (!cpu_active) begin
         r = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            cpu_active = 1'b1;
            cpu_req    = 1'b1;
            cpu_write  = r[20];
            cpu_addr   = {r[15:14], 10'h000, r[3:0]};
            cpu_wdata  = r[31:24];
         end else begin
            cpu_req = 1'b0;
         end
      end
      if (!vdp_active) begin
         r = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            vdp_active = 1'b1;
            vdp_req    = 1'b1;
            vdp_addr   = {r[15:14], 10'h000, r[3:0]};
         end else begin
            vdp_req = 1'b0;
         end
      end
      vdp_urgent = ($urandom_range(0, 3) == 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] r;
      reset = 1'b1;  ram_load = 1'b1;
      cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vdp_req = 1'b0; vdp_urgent = 1'b0; vdp_addr = '0;
      cpu_active = 1'b0; vdp_active = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         r = $urandom;
         gold_mem[i] = r[7:0];
      end
      gold_mem[16'h4000] = 8'hA5;
      @(posedge clk);
      #1;
      ram_load = 1'b0;
      do_reset();

      // read 0x4000 -> A5
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h4000;
      sample();
      check("t1_addr", 32'(ram_addr), 32'(16'h4000));
      check("t1_we", 32'(ram_we), 32'(1'b0));
      advance();
      sample();
      check("t1_ack", 32'(cpu_ack), 32'(1'b1));
      check("t1_rdata", 32'(cpu_rdata), 32'(8'hA5));
      check("t1_vack", 32'(vdp_ack), 32'(1'b0));
      advance();

      // write 3C to 0x8001, then read it back
      cpu_write = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 8'h3C;
      sample();
      check("t2_we", 32'(ram_we), 32'(1'b1));
      check("t2_wdata", 32'(ram_wdata), 32'(8'h3C));
      advance();
      sample();
      check("t2_ack", 32'(cpu_ack), 32'(1'b1));
      advance();
      cpu_write = 1'b0;
      sample();
      advance();
      sample();
      check("t2_rd_ack", 32'(cpu_ack), 32'(1'b1));
      check("t2_rdata", 32'(cpu_rdata), 32'(8'h3C));
      advance();

      // ROM write: acked, never written
      cpu_write = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
      sample();
      check("t3_we_issue", 32'(ram_we), 32'(1'b0));
      advance();
      sample();
      check("t3_we_ack", 32'(ram_we), 32'(1'b0));
      check("t3_ack", 32'(cpu_ack), 32'(1'b1));
      advance();
      cpu_req = 1'b0; cpu_write = 1'b0;
      sample();
      check("t3_we_idle", 32'(ram_we), 32'(1'b0));
      advance();

      // both requesting, not urgent: CPU,VDP,CPU,VDP...
      do_reset();
      issue_log.delete();
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h4010;
      vdp_req = 1'b1; vdp_urgent = 1'b0; vdp_addr = 16'h8020;
      repeat (8) begin sample(); advance(); end
      for (int i = 0; i < 8; i++)
         check($sformatf("t4_order%0d", i), 32'(issue_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      cpu_req = 1'b0; vdp_req = 1'b0;
      sample(); advance();

      // urgent VDP, then round-robin resumes with CPU winning the tie
      issue_log.delete();
      cpu_req = 1'b1; vdp_req = 1'b1; vdp_urgent = 1'b1;
      repeat (7) begin sample(); advance(); end
      cpu_req = 1'b0; vdp_urgent = 1'b0;
      sample(); advance();
      cpu_req = 1'b1;
      repeat (2) begin sample(); advance(); end
      for (int i = 0; i < 7; i++)
         check($sformatf("t5_order%0d", i), 32'(issue_log[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("t5_gap", 32'(issue_log[7]), 32'd0);
      check("t5_tie_cpu", 32'(issue_log[8]), 32'd1);
      check("t5_then_vdp", 32'(issue_log[9]), 32'd2);
      cpu_req = 1'b0; vdp_req = 1'b0;
      sample(); advance();

      // reset in the ack cycle of a CPU read
      issue_log.delete();
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h4000;
      sample(); advance();
      reset = 1'b1;
      sample();
      check("t6_ack_killed", 32'(cpu_ack), 32'(1'b0));
      advance();
      reset = 1'b0;
      vdp_req = 1'b1; vdp_urgent = 1'b0; vdp_addr = 16'h8020;
      repeat (3) begin sample(); advance(); end
      check("t6_first_cpu", 32'(issue_log[1]), 32'd1);
      check("t6_then_vdp", 32'(issue_log[2]), 32'd2);
      check("t6_cpu_again", 32'(issue_log[3]), 32'd1);
      cpu_req = 1'b0; vdp_req = 1'b0;
      sample(); advance();

      // randomized traffic with one mid-run reset
      cpu_active = 1'b0; vdp_active = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         reset = (i == 1500);
         drive_random();
         sample();
         advance();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
